// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller.
//   - state_e           : controller state encoding (IDLE/RUN/DONE)
//   - SERIAL_ADD_WIDTH  : default operand/sum width
package serial_add_pkg;

    localparam int unsigned SERIAL_ADD_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : serial_add_pkg

// File: rtl/full_adder.sv
// Single-bit full adder (combinational).
//   A, B, Cin : addend bits and carry-in
//   Sum, Cout : sum bit and carry-out
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);

    assign Sum  = A ^ B ^ Cin;
    assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule : full_adder

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands over WIDTH cycles
// using one full_adder, LSB first, with a registered carry.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : operand handshake (a, b, cin sampled on accept)
//   out_valid/out_ready  : result handshake (sum, cout held until taken)
//   ovf                  : signed overflow, only when SERIAL_ADD_OVF_EN is defined
// Optional feature macro: SERIAL_ADD_OVF_EN
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = SERIAL_ADD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e             state_q;
    logic [WIDTH-1:0]   a_sh_q;
    logic [WIDTH-1:0]   b_sh_q;
    logic [WIDTH-1:0]   sum_sh_q;
    logic               carry_q;
    logic               cout_q;
    logic [CNT_W-1:0]   cnt_q;
`ifdef SERIAL_ADD_OVF_EN
    logic               ovf_q;
`endif

    logic               fa_sum_c;
    logic               fa_cout_c;
    logic               last_c;

    // The one and only adder cell, fed from the shift register LSBs.
    full_adder u_fa (
        .A    (a_sh_q[0]),
        .B    (b_sh_q[0]),
        .Cin  (carry_q),
        .Sum  (fa_sum_c),
        .Cout (fa_cout_c)
    );

    assign last_c = (cnt_q == CNT_W'(WIDTH - 1));

    // Controller FSM and datapath registers.
    // sum_sh_q doubles as the result register: after the final shift it holds
    // the complete sum and is left untouched until the next accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            cnt_q    <= '0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_sh_q   <= a_sh_q >> 1;
                    b_sh_q   <= b_sh_q >> 1;
                    sum_sh_q <= {fa_sum_c, sum_sh_q[WIDTH-1:1]};
                    carry_q  <= fa_cout_c;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (last_c) begin
                        cout_q  <= fa_cout_c;
`ifdef SERIAL_ADD_OVF_EN
                        // carry_q here is the carry into the MSB
                        ovf_q   <= carry_q ^ fa_cout_c;
`endif
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Handshake flags are pure decodes of the state register.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_sh_q;
    assign cout      = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule : serial_add_ctrl

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): directed and random
// operations checked against plain-arithmetic expectations.
module tb_serial_add_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int errors = 0;
    int checks = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0: plain op; 1: pulse in_valid with other operands during RUN;
    // 2: hold out_ready low for 5 cycles once the result is valid.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tc, input int mode);
        logic [W:0]   exp;
        logic         exp_ovf;
        int           n;
        int           lat;
        exp     = {1'b0, ta} + {1'b0, tb_v} + (W+1)'(tc);
        exp_ovf = (ta[W-1] == tb_v[W-1]) && (exp[W-1] != ta[W-1]);

        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("in_ready_before_accept", 64'(in_ready), 64'(1));

        a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        check("in_ready_in_run", 64'(in_ready), 64'(0));

        lat = 0;
        while (!out_valid && lat < 200) begin
            if (mode == 1 && lat == 2) begin
                a = 8'h11; b = 8'h11; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        check("latency", 64'(lat), 64'(W));
        check("sum", 64'(sum), 64'(exp[W-1:0]));
        check("cout", 64'(cout), 64'(exp[W]));
`ifdef SERIAL_ADD_OVF_EN
        check("ovf", 64'(ovf), 64'(exp_ovf));
`endif

        if (mode == 2) begin
            for (int i = 0; i < 5; i++) begin
                @(posedge clk); #1;
                check("bp_out_valid", 64'(out_valid), 64'(1));
                check("bp_in_ready", 64'(in_ready), 64'(0));
                check("bp_sum", 64'(sum), 64'(exp[W-1:0]));
                check("bp_cout", 64'(cout), 64'(exp[W]));
            end
        end

        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("in_ready_after_take", 64'(in_ready), 64'(1));
        check("out_valid_after_take", 64'(out_valid), 64'(0));
        if (exp_ovf && 1'b0) check("unused", 64'(0), 64'(1));
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_sum", 64'(sum), 64'(0));
        check("rst_cout", 64'(cout), 64'(0));
`ifdef SERIAL_ADD_OVF_EN
        check("rst_ovf", 64'(ovf), 64'(0));
`endif
        rst = 1'b0;

        // Directed cases
        run_op(8'h5A, 8'h3C, 1'b0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 0);
        run_op(8'hFF, 8'hFF, 1'b1, 0);
        run_op(8'h12, 8'h34, 1'b1, 2);
        run_op(8'h01, 8'h01, 1'b0, 1);
        run_op(8'h7F, 8'h01, 1'b0, 0);
        run_op(8'h80, 8'h80, 1'b0, 0);

        // Reset in the middle of RUN discards the partial result
        a = 8'hAA; b = 8'h55; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_in_ready", 64'(in_ready), 64'(1));
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_sum", 64'(sum), 64'(0));
        check("midrst_cout", 64'(cout), 64'(0));
        repeat (W + 2) @(posedge clk);
        #1;
        check("midrst_no_result", 64'(out_valid), 64'(0));
        run_op(8'h10, 8'h20, 1'b0, 0);

        // Reset together with in_valid: nothing accepted
        a = 8'h33; b = 8'h44; in_valid = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        check("rst_vs_valid_idle", 64'(in_ready), 64'(1));
        repeat (W + 2) @(posedge clk);
        #1;
        check("rst_vs_valid_no_out", 64'(out_valid), 64'(0));

        // Random operations
        for (int i = 0; i < 20; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_serial_add_ctrl
